// File: rtl/pic_core_pkg.sv
// Shared types and instruction encodings for the PIC16-style core.
package pic_core_pkg;

    localparam int PC_WIDTH      = 11;
    localparam int INSTR_WIDTH   = 14;
    localparam int STACK_ENTRIES = 8;

    localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 11'h000;

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    // Opcode patterns; GOTO/CALL match on bits [13:11], RETLW on [13:10].
    localparam logic [2:0] OP_GOTO      = 3'b101;
    localparam logic [2:0] OP_CALL      = 3'b100;
    localparam logic [3:0] OP_RETLW     = 4'b1101;
    localparam instr_t     INSTR_RETURN = 14'h0008;
    localparam instr_t     INSTR_NOP    = 14'h0000;

endpackage

// File: rtl/call_stack.sv
// Hardware return stack: circular buffer with a wrapping pointer, an
// occupancy count and sticky overflow/underflow flags.
module call_stack #(
    parameter int STACK_DEPTH = 8,
    parameter int PC_W        = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            ovf,
    output logic            unf
);

    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W:0] FULL = (SP_W + 1)'(STACK_DEPTH);

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_top;
    logic [SP_W:0]   count;

    // Top of stack is the slot just below the write pointer; an empty pop
    // still reads it, matching the silicon.
    assign sp_top = sp - SP_W'(1);
    assign dout   = mem[sp_top];

    // Entry storage carries no reset; a full push simply overwrites the oldest.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= din;
        end
    end

    // Pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            sp <= sp + SP_W'(1);
            if (count == FULL) begin
                ovf <= 1'b1;
            end else begin
                count <= count + (SP_W + 1)'(1);
            end
        end else if (pop) begin
            sp <= sp_top;
            if (count == '0) begin
                unf <= 1'b1;
            end else begin
                count <= count - (SP_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: two-stage fetch/execute with
// GOTO/CALL/RETURN/RETLW, computed PCL writes and skips.
module pc_fetch_ctrl #(
    parameter int                 PC_W         = pic_core_pkg::PC_WIDTH,
    parameter int                 INSTR_W      = pic_core_pkg::INSTR_WIDTH,
    parameter int                 STACK_DEPTH  = pic_core_pkg::STACK_ENTRIES,
    parameter logic [PC_W-1:0]    RESET_VECTOR = pic_core_pkg::RESET_VECTOR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [INSTR_W-1:0] Rom_data_in,
    input  logic               skip_req,
    input  logic               pcl_we,
    input  logic [7:0]         pcl_data,
    input  logic [4:0]         pclath,
    output logic [PC_W-1:0]    Rom_addr_out,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    output logic               stack_ovf,
    output logic               stack_unf
);

    import pic_core_pkg::*;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic [INSTR_W-1:0] ir;
    logic               ir_vld;
    logic               vld_next;
    logic               is_goto;
    logic               is_call;
    logic               is_ret;
    logic               push_en;
    logic               pop_en;
    logic [PC_W-1:0]    stack_dout;

    // GOTO/CALL target: PCLATH[4:3] prepended, then cut to the PC width.
    function automatic logic [PC_W-1:0] jump_target(input logic [INSTR_W-1:0] w,
                                                    input logic [4:0]         plath);
        logic [12:0] full;
        full = {plath[4:3], w[10:0]};
        return full[PC_W-1:0];
    endfunction

    // Computed goto: PCLATH[2:0] supplies the bits above PCL.
    function automatic logic [PC_W-1:0] pcl_target(input logic [4:0] plath,
                                                   input logic [7:0] pcl);
        logic [10:0] full;
        full = {plath[2:0], pcl};
        return full[PC_W-1:0];
    endfunction

    // A bubble in IR never decodes, whatever bits it happens to hold.
    assign is_goto = ir_vld && (ir[INSTR_W-1 -: 3] == OP_GOTO);
    assign is_call = ir_vld && (ir[INSTR_W-1 -: 3] == OP_CALL);
    assign is_ret  = ir_vld && ((ir == INSTR_RETURN) || (ir[INSTR_W-1 -: 4] == OP_RETLW));

    // Next-PC selection in priority order; stall only masks the stack side
    // effects here, the registers themselves hold below.
    always_comb begin
        pc_next  = pc + PC_W'(1);
        vld_next = 1'b1;
        push_en  = 1'b0;
        pop_en   = 1'b0;
        if (is_goto) begin
            pc_next  = jump_target(ir, pclath);
            vld_next = 1'b0;
        end else if (is_call) begin
            push_en  = 1'b1;
            pc_next  = jump_target(ir, pclath);
            vld_next = 1'b0;
        end else if (is_ret) begin
            pop_en   = 1'b1;
            pc_next  = stack_dout;
            vld_next = 1'b0;
        end else if (pcl_we) begin
            pc_next  = pcl_target(pclath, pcl_data);
            vld_next = 1'b0;
        end else if (skip_req) begin
            vld_next = 1'b0;
        end
        if (stall) begin
            push_en = 1'b0;
            pop_en  = 1'b0;
        end
    end

    // PC and instruction register; the fetched word is always captured and a
    // flush just marks it invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_VECTOR;
            ir     <= INSTR_NOP;
            ir_vld <= 1'b0;
        end else if (!stall) begin
            pc     <= pc_next;
            ir     <= Rom_data_in;
            ir_vld <= vld_next;
        end
    end

    // CALL pushes PC, which already points one past the CALL.
    call_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PC_W        (PC_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push_en),
        .pop   (pop_en),
        .din   (pc),
        .dout  (stack_dout),
        .ovf   (stack_ovf),
        .unf   (stack_unf)
    );

    assign Rom_addr_out = pc;
    assign ir_out       = ir;
    assign ir_valid     = ir_vld;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: a ROM model plus a per-cycle scoreboard of
// stimulus and expected PC/IR/flag values.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [13:0] Rom_data_in;
    logic        skip_req;
    logic        pcl_we;
    logic [7:0]  pcl_data;
    logic [4:0]  pclath;
    logic [10:0] Rom_addr_out;
    logic [13:0] ir_out;
    logic        ir_valid;
    logic        stack_ovf;
    logic        stack_unf;

    logic [13:0] rom [0:2047];
    assign Rom_data_in = rom[Rom_addr_out];

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .Rom_data_in  (Rom_data_in),
        .skip_req     (skip_req),
        .pcl_we       (pcl_we),
        .pcl_data     (pcl_data),
        .pclath       (pclath),
        .Rom_addr_out (Rom_addr_out),
        .ir_out       (ir_out),
        .ir_valid     (ir_valid),
        .stack_ovf    (stack_ovf),
        .stack_unf    (stack_unf)
    );

    typedef struct {
        logic        st;
        logic        sk;
        logic        pw;
        logic [4:0]  pl;
        logic [7:0]  pd;
        logic [10:0] pc;
        logic        vld;
        logic [13:0] ir;
        logic        ovf;
        logic        unf;
    } step_t;

    step_t sb[$];
    step_t s;
    int    n_vec = 0;
    int    n_err = 0;
    logic  exp_ovf;
    logic  exp_unf;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic init_rom();
        for (int a = 0; a < 2048; a++) rom[a] = 14'h0800 | 14'(a);
        rom[11'h000] = 14'h01A5;
        rom[11'h001] = 14'h0103;
        rom[11'h002] = 14'h3001;
        rom[11'h008] = 14'h2012;   // CALL 0x012
        rom[11'h00A] = 14'h2805;   // GOTO 0x005
        rom[11'h00B] = 14'h2830;   // GOTO encoding that only ever sits in a bubble
        rom[11'h016] = 14'h0BA2;
        rom[11'h01C] = 14'h0008;   // RETURN
        rom[11'h01D] = 14'h2840;   // GOTO encoding that only ever sits in a bubble
        // Nine nested calls 0x100 -> 0x110 -> ... -> 0x190, then a RETURN chain.
        for (int k = 0; k < 9; k++) rom[11'h100 + 16 * k] = 14'h2000 | 14'(11'h100 + 16 * (k + 1));
        rom[11'h190] = 14'h0008;
        for (int k = 1; k < 9; k++) rom[11'h101 + 16 * k] = 14'h0008;
    endtask

    task automatic add(input logic st, input logic sk, input logic pw, input logic [4:0] pl,
                       input logic [7:0] pd, input logic [10:0] pc, input logic vld,
                       input logic [13:0] ir);
        step_t e;
        e.st = st; e.sk = sk; e.pw = pw; e.pl = pl; e.pd = pd;
        e.pc = pc; e.vld = vld; e.ir = ir; e.ovf = exp_ovf; e.unf = exp_unf;
        sb.push_back(e);
    endtask

    // Sequential fetch of address a: IR gets rom[a], PC moves to a+1.
    task automatic fetch(input int a);
        add(1'b0, 1'b0, 1'b0, 5'h0, 8'h0, 11'(a + 1), 1'b1, rom[a]);
    endtask

    task automatic bubble(input int pc);
        add(1'b0, 1'b0, 1'b0, 5'h0, 8'h0, 11'(pc), 1'b0, 14'h0);
    endtask

    task automatic do_reset();
        stall = 1'b0; skip_req = 1'b0; pcl_we = 1'b0; pclath = 5'h0; pcl_data = 8'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b0; skip_req = 1'b0; pcl_we = 1'b0; pclath = 5'h0; pcl_data = 8'h0;
        exp_ovf = 1'b0; exp_unf = 1'b0;
        reset = 1'b1;
        #2;
        n_vec++; if (Rom_addr_out !== 11'h000) begin n_err++; $display("FAIL reset_pc: got %h want 000", Rom_addr_out); end
        n_vec++; if (ir_out !== 14'h0000) begin n_err++; $display("FAIL reset_ir: got %h want 0000", ir_out); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
        n_vec++; if ({stack_ovf, stack_unf} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {stack_ovf, stack_unf}); end
        @(posedge clk);
        #1 reset = 1'b0;
        n_vec++; if (Rom_addr_out !== 11'h000 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL release_state: pc=%h v=%b want pc=000 v=0", Rom_addr_out, ir_valid);
        end
        fetch(0); fetch(1); fetch(2);
        for (int i = 0; sb.size() != 0; i++) begin
            s = sb.pop_front();
            stall = s.st; skip_req = s.sk; pcl_we = s.pw; pclath = s.pl; pcl_data = s.pd;
            @(posedge clk); #1;
            n_vec++;
            if (Rom_addr_out !== s.pc || ir_valid !== s.vld || (s.vld && ir_out !== s.ir) ||
                stack_ovf !== s.ovf || stack_unf !== s.unf) begin
                n_err++;
                $display("FAIL reset_seq step %0d: pc=%h v=%b ir=%h of=%b uf=%b, want pc=%h v=%b ir=%h of=%b uf=%b",
                         i, Rom_addr_out, ir_valid, ir_out, stack_ovf, stack_unf, s.pc, s.vld, s.ir, s.ovf, s.unf);
            end
        end
    endtask

    // CALL at 8 (with skip/pcl requests that must be ignored), RETURN at 0x1C,
    // then GOTO 5 at 0xA; bubbles that hold GOTO encodings must not jump.
    task automatic test_branch();
        do_reset();
        for (int a = 0; a <= 8; a++) fetch(a);
        add(1'b0, 1'b1, 1'b1, 5'h1F, 8'hFF, 11'h012, 1'b0, 14'h0);
        for (int a = 8'h12; a <= 8'h1C; a++) fetch(a);
        bubble(11'h009);
        fetch(11'h009); fetch(11'h00A);
        bubble(11'h005);
        fetch(11'h005); fetch(11'h006);
        for (int i = 0; sb.size() != 0; i++) begin
            s = sb.pop_front();
            stall = s.st; skip_req = s.sk; pcl_we = s.pw; pclath = s.pl; pcl_data = s.pd;
            @(posedge clk); #1;
            n_vec++;
            if (Rom_addr_out !== s.pc || ir_valid !== s.vld || (s.vld && ir_out !== s.ir) ||
                stack_ovf !== s.ovf || stack_unf !== s.unf) begin
                n_err++;
                $display("FAIL branch step %0d: pc=%h v=%b ir=%h of=%b uf=%b, want pc=%h v=%b ir=%h of=%b uf=%b",
                         i, Rom_addr_out, ir_valid, ir_out, stack_ovf, stack_unf, s.pc, s.vld, s.ir, s.ovf, s.unf);
            end
        end
    endtask

    // Skip resolved while 0BA2 (at 0x16) executes: word at 0x17 is dropped.
    task automatic test_skip();
        do_reset();
        for (int a = 0; a <= 8; a++) fetch(a);
        bubble(11'h012);
        for (int a = 8'h12; a <= 8'h16; a++) fetch(a);
        add(1'b0, 1'b1, 1'b0, 5'h0, 8'h0, 11'h018, 1'b0, 14'h0);
        fetch(11'h018); fetch(11'h019);
        for (int i = 0; sb.size() != 0; i++) begin
            s = sb.pop_front();
            stall = s.st; skip_req = s.sk; pcl_we = s.pw; pclath = s.pl; pcl_data = s.pd;
            @(posedge clk); #1;
            n_vec++;
            if (Rom_addr_out !== s.pc || ir_valid !== s.vld || (s.vld && ir_out !== s.ir) ||
                stack_ovf !== s.ovf || stack_unf !== s.unf) begin
                n_err++;
                $display("FAIL skip step %0d: pc=%h v=%b ir=%h of=%b uf=%b, want pc=%h v=%b ir=%h of=%b uf=%b",
                         i, Rom_addr_out, ir_valid, ir_out, stack_ovf, stack_unf, s.pc, s.vld, s.ir, s.ovf, s.unf);
            end
        end
    endtask

    // PCL jump to 0x100, nine nested CALLs, nine RETURNs, then async reset.
    task automatic test_nested();
        int ret_addr;
        int popped;
        do_reset();
        fetch(0);
        add(1'b0, 1'b0, 1'b1, 5'b11001, 8'h00, 11'h100, 1'b0, 14'h0);
        for (int k = 0; k < 9; k++) begin
            fetch(11'h100 + 16 * k);
            if (k == 8) exp_ovf = 1'b1;
            bubble(11'h100 + 16 * (k + 1));
        end
        ret_addr = 11'h190;
        for (int j = 1; j <= 9; j++) begin
            fetch(ret_addr);
            popped = (j <= 8) ? (11'h181 - 16 * (j - 1)) : 11'h181;
            if (j == 9) exp_unf = 1'b1;
            bubble(popped);
            ret_addr = popped;
        end
        for (int i = 0; sb.size() != 0; i++) begin
            s = sb.pop_front();
            stall = s.st; skip_req = s.sk; pcl_we = s.pw; pclath = s.pl; pcl_data = s.pd;
            @(posedge clk); #1;
            n_vec++;
            if (Rom_addr_out !== s.pc || ir_valid !== s.vld || (s.vld && ir_out !== s.ir) ||
                stack_ovf !== s.ovf || stack_unf !== s.unf) begin
                n_err++;
                $display("FAIL nested step %0d: pc=%h v=%b ir=%h of=%b uf=%b, want pc=%h v=%b ir=%h of=%b uf=%b",
                         i, Rom_addr_out, ir_valid, ir_out, stack_ovf, stack_unf, s.pc, s.vld, s.ir, s.ovf, s.unf);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_vec++; if ({stack_ovf, stack_unf} !== 2'b00) begin n_err++; $display("FAIL flags_async_clear: got %b want 00", {stack_ovf, stack_unf}); end
        n_vec++; if (Rom_addr_out !== 11'h000 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL nested_async_reset: pc=%h v=%b want pc=000 v=0", Rom_addr_out, ir_valid);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Three stall cycles mid-stream, one stall over a pending CALL, then an
    // async reset in the middle of the CALL's execute cycle.
    task automatic test_stall_reset();
        do_reset();
        fetch(0); fetch(1); fetch(2);
        for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b0, 5'h0, 8'h0, 11'h003, 1'b1, rom[2]);
        for (int a = 3; a <= 8; a++) fetch(a);
        add(1'b1, 1'b0, 1'b0, 5'h0, 8'h0, 11'h009, 1'b1, rom[8]);
        for (int i = 0; sb.size() != 0; i++) begin
            s = sb.pop_front();
            stall = s.st; skip_req = s.sk; pcl_we = s.pw; pclath = s.pl; pcl_data = s.pd;
            @(posedge clk); #1;
            n_vec++;
            if (Rom_addr_out !== s.pc || ir_valid !== s.vld || (s.vld && ir_out !== s.ir) ||
                stack_ovf !== s.ovf || stack_unf !== s.unf) begin
                n_err++;
                $display("FAIL stall step %0d: pc=%h v=%b ir=%h of=%b uf=%b, want pc=%h v=%b ir=%h of=%b uf=%b",
                         i, Rom_addr_out, ir_valid, ir_out, stack_ovf, stack_unf, s.pc, s.vld, s.ir, s.ovf, s.unf);
            end
        end
        stall = 1'b0;
        #3 reset = 1'b1;
        #1;
        n_vec++; if (Rom_addr_out !== 11'h000) begin n_err++; $display("FAIL midcall_reset_pc: got %h want 000", Rom_addr_out); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL midcall_reset_valid: got %b want 0", ir_valid); end
        n_vec++; if ({stack_ovf, stack_unf} !== 2'b00) begin n_err++; $display("FAIL midcall_reset_flags: got %b want 00", {stack_ovf, stack_unf}); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (Rom_addr_out !== 11'h001 || ir_valid !== 1'b1 || ir_out !== 14'h01A5) begin
            n_err++; $display("FAIL restart_fetch: pc=%h v=%b ir=%h want pc=001 v=1 ir=01a5", Rom_addr_out, ir_valid, ir_out);
        end
    endtask

    initial begin
        init_rom();
        test_reset();
        test_branch();
        test_skip();
        test_nested();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer for the 2K x 14-bit program ROM of the PIC16-style core.
- Drives the ROM address, captures the returned word into an instruction register and hands it to the execute datapath.
- Resolves GOTO, CALL, RETURN, RETLW, computed-PCL writes and skips, using an 8-level hardware return stack.
- Two-stage fetch/execute pipeline: a taken control transfer flushes one fetched word.

Parameters:
- PC_W, 11, program counter and ROM address width.
- INSTR_W, 14, instruction width.
- STACK_DEPTH, 8, return-stack entries (power of 2).
- RESET_VECTOR, 11'h000, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freeze PC, IR, ir_valid and stack this cycle.
- Rom_data_in  input  INSTR_W  ROM word for the current Rom_addr_out (combinational ROM).
- skip_req  input  1  datapath: the instruction now in IR resolved a skip (BTFSS/BTFSC/DECFSZ/INCFSZ).
- pcl_we  input  1  datapath write to PCL (computed goto).
- pcl_data  input  8  value written to PCL.
- pclath  input  5  current PCLATH register.
- Rom_addr_out  output  PC_W  equals PC; drives the ROM address.
- ir_out  output  INSTR_W  instruction register to decode/execute.
- ir_valid  output  1  ir_out is a real instruction; 0 means a bubble, executed as NOP.
- stack_ovf  output  1  sticky: push attempted while the stack held STACK_DEPTH entries.
- stack_unf  output  1  sticky: pop attempted on an empty stack.

Behaviour:
- Reset (async):
  - PC=RESET_VECTOR; ir_out=14'h0000; ir_valid=0.
  - Stack pointer=0; entry count=0; stack_ovf=stack_unf=0.
  - Stack contents are don't-care.
  - The first valid IR appears one cycle after reset deasserts.
- Normal cycle (no stall):
  - ir_out<=Rom_data_in; ir_valid<=1.
  - PC<=PC+1, wrapping 11'h7FF to 11'h000.
  - While IR executes, PC = IR address + 1.
- Decode, acted on only when ir_valid=1 (constants in package):
  - GOTO: 3'b101 in bits [13:11]; target k = {pclath[4:3], ir[10:0]} truncated to PC_W. With an 11-bit PC this is ir[10:0].
  - CALL: 3'b100 in bits [13:11]; same target.
  - RETURN: 14'h0008.
  - RETLW: bits [13:10] = 4'b1101.
- Priority per cycle, highest first; only one action applies:
  1. reset.
  2. stall: hold all state. The ROM address stays stable, so Rom_data_in is re-fetched next cycle.
  3. GOTO: PC<=target; ir_valid<=0 (flush).
  4. CALL: push current PC; PC<=target; flush.
  5. RETURN/RETLW: PC<=popped TOS; flush. The RETLW literal-to-W transfer is performed by the datapath from ir_out.
  6. pcl_we: PC<={pclath[2:0], pcl_data}; flush.
  7. skip_req: PC<=PC+1; ir_valid<=0. The fetched next instruction is discarded, not re-fetched.
  8. Otherwise: normal cycle.
- skip_req or pcl_we arriving together with a GOTO/CALL/RETURN in IR is ignored.
- A flushed slot (ir_valid=0) never triggers decode, even if ir_out holds a branch encoding.
- Stack:
  - Circular buffer with a 3-bit pointer.
  - Push writes mem[sp], then sp<=sp+1.
  - Pop reads mem[sp-1], then sp<=sp-1.
  - Push with count=STACK_DEPTH: overwrites the oldest entry (PIC behaviour); count stays 8; stack_ovf<=1.
  - Pop with count=0: still returns mem[sp-1] and decrements sp; stack_unf<=1.
  - Flags clear only on reset.
  - Worst-case latency: branch penalty = 1 bubble; stall adds cycles 1:1.

Decomposition:
- Package pic_core_pkg:
  - typedefs pc_t (logic[PC_W-1:0]) and instr_t (logic[INSTR_W-1:0]).
  - Opcode masks/patterns: OP_GOTO, OP_CALL, INSTR_RETURN=14'h0008, OP_RETLW, INSTR_NOP=14'h0000.
  - RESET_VECTOR.
- Sub-module call_stack (push, pop, din, dout, ovf, unf), parameterised by STACK_DEPTH and PC_W.

Test Plan:
- Reset release, ROM at 0:01A5, 1:0103, 2:3001 -> Rom_addr_out 0,1,2,3 on successive cycles; ir_out 01A5 with ir_valid=1 in the cycle after reset deasserts.
- IR=2805 (GOTO 5) fetched from addr 0xA -> next cycle Rom_addr_out=0x005, ir_valid=0; following cycle ir_out=word@5.
- CALL 0x012 (2012) at addr 8, then RETURN (0008) at 0x1C -> stack holds 0x009; PC=0x012, then 0x009 after RETURN; one bubble each; no flags.
- skip_req=1 while IR=0BA2 at 0x16 -> word at 0x17 discarded (ir_valid=0); next valid IR from 0x18.
- Nine nested CALLs then nine RETURNs -> stack_ovf=1 after the 9th call; returns 1-8 give the last eight pushed addresses; the 9th return sets stack_unf=1.
- stall held 3 cycles mid-stream, plus reset asserted mid-CALL -> PC/IR frozen during stall; on reset PC=0x000, ir_valid=0, flags cleared immediately (async).
